// File: rtl/npu_ofmap_drain.sv
// Drains one WxW signed accumulator tile and requantizes it to N-bit activations, one packed row per word.
// Optional DRAIN_ROUND_EN selects round-half-up before the shift; the default build truncates.
module npu_ofmap_drain #(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 2,
  parameter int unsigned BG    = 6,
  parameter int unsigned ACC_W = 2 * N + BG,
  parameter int unsigned SH_W  = 4,
  localparam int unsigned ROW_W = $clog2(W)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tile_vld,
  output logic                   tile_rdy,
  input  logic [W*W*ACC_W-1:0]   tile_acc,
  input  logic [SH_W-1:0]        tile_shamt,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [W*N-1:0]         out_data,
  output logic [ROW_W-1:0]       out_row,
  output logic                   out_last,
  output logic                   busy
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_DRAIN = 1'b1;

`ifdef DRAIN_ROUND_EN
  localparam logic signed [ACC_W:0] RND_ONE = 1;
`endif

  logic                   state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [W*W*ACC_W-1:0]   cap_q;
  logic [SH_W-1:0]        shamt_q;

  logic accept;
  logic last_row;
  logic last_hs;

  // Requantize one pixel at ACC_W+1 bits; shifts of ACC_W or more always give zero.
  function automatic logic [N-1:0] requant(input logic [ACC_W-1:0] acc,
                                           input logic [SH_W-1:0]  sh);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] q;
    ext = signed'({acc[ACC_W-1], acc});
`ifdef DRAIN_ROUND_EN
    if ((sh != '0) && (int'(sh) < int'(ACC_W))) begin
      ext = ext + (RND_ONE << (sh - 1'b1));
    end
`endif
    q = ext >>> sh;
    if ((int'(sh) >= int'(ACC_W)) || q[ACC_W]) begin
      requant = '0;
    end else if (|q[ACC_W-1:N]) begin
      requant = {N{1'b1}};
    end else begin
      requant = q[N-1:0];
    end
  endfunction

  assign last_row = (row_q == ROW_W'(W - 1));
  assign last_hs  = (state_q == ST_DRAIN) && last_row && out_rdy;
  assign tile_rdy = (state_q == ST_IDLE) || last_hs;
  assign accept   = tile_vld && tile_rdy;

  assign out_vld  = (state_q == ST_DRAIN);
  assign busy     = (state_q == ST_DRAIN);
  assign out_row  = row_q;
  assign out_last = (state_q == ST_DRAIN) && last_row;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DRAIN;
          row_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (out_rdy) begin
          if (last_row) begin
            // A tile accepted on the final handshake keeps the drain running without a bubble.
            state_d = accept ? ST_DRAIN : ST_IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        row_d   = '0;
      end
    endcase
  end

  always_comb begin
    logic [W*ACC_W-1:0] row_acc;
    logic [W*N-1:0]     pix;
    row_acc = '0;
    pix     = '0;
    for (int r = 0; r < int'(W); r++) begin
      if (row_q == ROW_W'(r)) begin
        row_acc = cap_q[r*W*ACC_W +: W*ACC_W];
      end
    end
    for (int c = 0; c < int'(W); c++) begin
      pix[c*N +: N] = requant(row_acc[c*ACC_W +: ACC_W], shamt_q);
    end
    out_data = (state_q == ST_DRAIN) ? pix : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q   <= '0;
      shamt_q <= '0;
    end else if (accept) begin
      cap_q   <= tile_acc;
      shamt_q <= tile_shamt;
    end
  end

endmodule
